// File: rtl/uart_rx_pico_if.sv
// Receive-side bundle between the serial line, the byte consumer and the status pulses.
interface uart_rx_pico_if;
   logic       rxd;
   logic       ack;
   logic [7:0] data;
   logic       valid;
   logic       busy;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   modport slave (
      input  rxd, ack,
      output data, valid, busy, frame_err, overrun, parity_err
   );

   modport master (
      output rxd, ack,
      input  data, valid, busy, frame_err, overrun, parity_err
   );
endinterface

// File: rtl/uart_rx_pico.sv
// 8N1 serial receiver with mid-bit sampling and a valid/ack holding register.
// Define UART_RX_PARITY_EN for 8E1 frames (even parity bit before stop, parity_err active).
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge on rxd_s
// START     | half-bit wait, confirm start bit still low
// DATA      | sampling 8 data bits LSB first, one per bit period
// PARITY    | sampling the even parity bit (parity builds only)
// STOP      | sampling the stop bit, flag good frame or framing error
// WAIT_HIGH | line held low after a bad stop, wait for it to return high
module uart_rx_pico #(
   parameter int CLKS_PER_BIT = 434
) (
   input logic            clk,
   input logic            rst,
   uart_rx_pico_if.slave  bus
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY    = 3'd3;
`endif
   localparam logic [2:0] STOP      = 3'd4;
   localparam logic [2:0] WAIT_HIGH = 3'd5;

   logic          rxd_m;
   logic          rxd_s;
   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shift;
   logic          done;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          frame_err_q;
   logic          overrun_q;
`ifdef UART_RX_PARITY_EN
   logic          par_bit;
   logic          parity_err_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_m        <= 1'b1;
         rxd_s        <= 1'b1;
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         shift        <= '0;
         done         <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit      <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         rxd_m       <= bus.rxd;
         rxd_s       <= rxd_m;
         done        <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (!rxd_s) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == CNT_HALF) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= rxd_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt        <= '0;
                  shift[idx] <= rxd_s;
                  if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt == CNT_LAST) begin
                  cnt     <= '0;
                  par_bit <= rxd_s;
                  state   <= STOP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
`endif
            STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt         <= '0;
                  frame_err_q <= !rxd_s;
`ifdef UART_RX_PARITY_EN
                  // a parity mismatch discards the byte even when the stop bit is good
                  parity_err_q <= (par_bit != ^shift);
                  done         <= rxd_s && (par_bit == ^shift);
`else
                  done         <= rxd_s;
`endif
                  state <= rxd_s ? IDLE : WAIT_HIGH;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WAIT_HIGH: begin
               if (rxd_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // an ack on the completion cycle frees the register for the new byte
         if (done) begin
            if (!valid_q || bus.ack) begin
               data_q  <= shift;
               valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (bus.ack) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.data      = data_q;
   assign bus.valid     = valid_q;
   assign bus.busy      = (state != IDLE);
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err = parity_err_q;
`else
   assign bus.parity_err = 1'b0;
`endif

endmodule
